// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializer_pkg
// Description : Shared state encoding and sizing helpers for fifo_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    function automatic int calc_ratio(input int in_width, input int out_width);
        return in_width / out_width;
    endfunction

    // A one-bit counter is kept even for degenerate ratios so widths stay legal.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : beat_counter
// Description : Counts beats 0..RATIO-1 within a word, saturating on the last.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_counter
    import serializer_pkg::*;
#(
    parameter int RATIO = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last
);

    localparam int                 c_CNT_W = cnt_width(RATIO);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(RATIO - 1);

    logic [c_CNT_W-1:0] r_beat;

    // Saturation guards against a stray enable on the final beat.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_beat <= '0;
        end else if (i_enable && (r_beat != c_LAST)) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    assign o_last = (r_beat == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fifo_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serializer
// Description : Pops wide FIFO words and emits them as tagged narrow beats.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_serializer
    import serializer_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_deq,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int c_RATIO = calc_ratio(IN_WIDTH, OUT_WIDTH);

    generate
        if ((IN_WIDTH % OUT_WIDTH != 0) || (c_RATIO < 2)) begin : g_bad_params
            $error("fifo_serializer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
        end
    endgenerate

    state_t              r_state;
    logic [IN_WIDTH-1:0] r_shreg;
    logic [IN_WIDTH-1:0] w_shreg_next;
    logic                r_valid;
    logic                r_busy;
    logic                w_last;
    logic                w_deq;

    // The last-beat pop overlaps the handshake so only one FETCH bubble is paid.
    assign w_deq = !reset && !fifo_empty &&
                   ((r_state == IDLE) || ((r_state == SEND) && w_last && out_ready));

    beat_counter #(
        .RATIO (c_RATIO)
    ) u_beat_counter (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (r_state == FETCH),
        .i_enable ((r_state == SEND) && out_ready),
        .o_last   (w_last)
    );

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign out_data     = r_shreg[IN_WIDTH-1 -: OUT_WIDTH];
            assign w_shreg_next = r_shreg << OUT_WIDTH;
        end else begin : g_lsb_first
            assign out_data     = r_shreg[OUT_WIDTH-1:0];
            assign w_shreg_next = r_shreg >> OUT_WIDTH;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_deq) begin
                        r_state <= FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    r_shreg <= fifo_data;
                    r_state <= SEND;
                    r_valid <= 1'b1;
                end
                SEND: begin
                    if (out_ready) begin
                        if (!w_last) begin
                            r_shreg <= w_shreg_next;
                        end else if (w_deq) begin
                            r_state <= FETCH;
                            r_valid <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_deq  = w_deq;
    assign out_valid = r_valid;
    assign out_last  = w_last;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_serializer
// Description : Self-checking bench for LSB-first and MSB-first serializers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_serializer;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    // seq[0] is the first beat on the wire, seq[3] the last.
    typedef struct packed {
        logic [63:0]       word;
        logic [3:0][15:0]  lsb_seq;
        logic [3:0][15:0]  msb_seq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_ready;

    logic        empty_l, deq_l, valid_l, last_l, busy_l;
    logic        empty_m, deq_m, valid_m, last_m, busy_m;
    logic [63:0] fdata_l, fdata_m;
    logic [15:0] data_l, data_m;

    logic [63:0] mem [16];
    int          wr_ptr = 0;
    int          rd_l   = 0;
    int          rd_m   = 0;

    beat_t       q_l[$];
    beat_t       q_m[$];
    vec_t        vecs[6];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fifo_serializer #(.IN_WIDTH(64), .OUT_WIDTH(16), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .fifo_empty(empty_l), .fifo_deq(deq_l),
        .fifo_data(fdata_l), .out_valid(valid_l), .out_ready(out_ready),
        .out_data(data_l), .out_last(last_l), .busy(busy_l)
    );

    fifo_serializer #(.IN_WIDTH(64), .OUT_WIDTH(16), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .fifo_empty(empty_m), .fifo_deq(deq_m),
        .fifo_data(fdata_m), .out_valid(valid_m), .out_ready(out_ready),
        .out_data(data_m), .out_last(last_m), .busy(busy_m)
    );

    // FIFO models: data_out is valid the cycle after deq is sampled.
    assign empty_l = (wr_ptr == rd_l);
    assign empty_m = (wr_ptr == rd_m);

    always @(posedge clk) begin
        if (deq_l) begin
            fdata_l <= mem[rd_l[3:0]];
            rd_l    <= rd_l + 1;
        end
        if (deq_m) begin
            fdata_m <= mem[rd_m[3:0]];
            rd_m    <= rd_m + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: observed %h at %0t", name, act, $time);
    endtask

    // Evaluated just before the edge, when the handshake inputs are final.
    task automatic score();
        beat_t e;
        if (reset) return;
        if (valid_l && out_ready) begin
            if (q_l.size() == 0) fail("lsb_unexpected_beat", {47'd0, data_l, last_l});
            else begin
                e = q_l.pop_front();
                chk("lsb_beat", {47'd0, data_l, last_l}, {47'd0, e});
            end
        end
        if (valid_m && out_ready) begin
            if (q_m.size() == 0) fail("msb_unexpected_beat", {47'd0, data_m, last_m});
            else begin
                e = q_m.pop_front();
                chk("msb_beat", {47'd0, data_m, last_m}, {47'd0, e});
            end
        end
        if (deq_l && empty_l) fail("lsb_deq_while_empty", 64'd1);
        if (deq_m && empty_m) fail("msb_deq_while_empty", 64'd1);
    endtask

    task automatic tick();
        @(negedge clk);
        score();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input vec_t v);
        mem[wr_ptr[3:0]] = v.word;
        wr_ptr++;
        for (int k = 0; k < 4; k++) begin
            q_l.push_back('{data: v.lsb_seq[k], last: (k == 3)});
            q_m.push_back('{data: v.msb_seq[k], last: (k == 3)});
        end
    endtask

    task automatic drain(input bit rnd, input int max_cyc);
        int n = 0;
        while ((q_l.size() != 0 || q_m.size() != 0 || busy_l || busy_m) && n < max_cyc) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk("drain_done", {63'd0, (n < max_cyc)}, 64'd1);
    endtask

    task automatic wait_valid(input int max_cyc);
        int n = 0;
        while (!valid_l && n < max_cyc) begin
            tick();
            n++;
        end
        chk("wait_valid", {63'd0, valid_l}, 64'd1);
    endtask

    initial begin
        int cyc, beats, bub;

        vecs[0] = '{64'h0011_2233_4455_6677, {16'h0011, 16'h2233, 16'h4455, 16'h6677},
                                             {16'h6677, 16'h4455, 16'h2233, 16'h0011}};
        vecs[1] = '{64'hFFFF_0000_AAAA_5555, {16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555},
                                             {16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF}};
        vecs[2] = '{64'h8000_0000_0000_0001, {16'h8000, 16'h0000, 16'h0000, 16'h0001},
                                             {16'h0001, 16'h0000, 16'h0000, 16'h8000}};
        vecs[3] = '{64'hDEAD_BEEF_CAFE_F00D, {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D},
                                             {16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD}};
        vecs[4] = '{64'h1111_2222_3333_0001, {16'h1111, 16'h2222, 16'h3333, 16'h0001},
                                             {16'h0001, 16'h3333, 16'h2222, 16'h1111}};
        vecs[5] = '{64'h4444_5555_6666_0002, {16'h4444, 16'h5555, 16'h6666, 16'h0002},
                                             {16'h0002, 16'h6666, 16'h5555, 16'h4444}};

        // Reset with a word already waiting: nothing may be popped.
        reset     = 1'b1;
        out_ready = 1'b1;
        push_vec(vecs[0]);
        repeat (3) tick();
        chk("rst_deq",   {63'd0, deq_l},   64'd0);
        chk("rst_valid", {63'd0, valid_l}, 64'd0);
        chk("rst_last",  {63'd0, last_l},  64'd0);
        chk("rst_busy",  {63'd0, busy_l},  64'd0);
        chk("rst_data",  {48'd0, data_l},  64'd0);
        chk("rst_deq_m", {63'd0, deq_m},   64'd0);

        // First-word latency: deq cycle, FETCH bubble, then the first beat.
        reset = 1'b0;
        #1;
        chk("idle_deq", {63'd0, deq_l}, 64'd1);
        tick();
        chk("fetch_valid", {63'd0, valid_l}, 64'd0);
        chk("fetch_busy",  {63'd0, busy_l},  64'd1);
        chk("fetch_deq",   {63'd0, deq_l},   64'd0);
        tick();
        chk("first_valid", {63'd0, valid_l}, 64'd1);
        chk("first_data",  {48'd0, data_l},  64'h6677);
        chk("first_msb",   {48'd0, data_m},  64'h0011);
        drain(1'b0, 40);

        for (int i = 1; i < 4; i++) begin
            push_vec(vecs[i]);
            drain(i == 3, 80);
        end

        // Backpressure on beat 1.
        push_vec(vecs[0]);
        wait_valid(20);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_data",  {48'd0, data_l}, 64'h4455);
            chk("bp_msb",   {48'd0, data_m}, 64'h2233);
            chk("bp_deq",   {63'd0, deq_l},  64'd0);
            chk("bp_valid", {63'd0, valid_l}, 64'd1);
        end
        out_ready = 1'b1;
        drain(1'b0, 40);

        // Back-to-back words: 8 beats in 9 cycles, one bubble.
        push_vec(vecs[4]);
        push_vec(vecs[5]);
        wait_valid(20);
        cyc = 0; beats = 0; bub = 0;
        while (beats < 8 && cyc < 30) begin
            if (valid_l) begin
                beats++;
                if (beats == 4) chk("b2b_deq_on_last", {63'd0, deq_l}, 64'd1);
                if (beats == 8) chk("b2b_no_deq_end",  {63'd0, deq_l}, 64'd0);
            end else begin
                bub++;
            end
            cyc++;
            tick();
        end
        chk("b2b_beats",   beats, 8);
        chk("b2b_cycles",  cyc,   9);
        chk("b2b_bubbles", bub,   1);
        drain(1'b0, 10);

        // Empty FIFO stays quiet.
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("empty_deq",   {63'd0, deq_l},   64'd0);
            chk("empty_valid", {63'd0, valid_l}, 64'd0);
            chk("empty_busy",  {63'd0, busy_l},  64'd0);
        end

        // Reset after beat 1 is accepted discards the rest of the word.
        push_vec(vecs[3]);
        wait_valid(20);
        tick();
        chk("mid_beat1", {48'd0, data_l}, 64'hCAFE);
        tick();
        reset = 1'b1;
        q_l.delete();
        q_m.delete();
        tick();
        chk("mid_rst_valid",   {63'd0, valid_l}, 64'd0);
        chk("mid_rst_busy",    {63'd0, busy_l},  64'd0);
        chk("mid_rst_busy_m",  {63'd0, busy_m},  64'd0);
        reset = 1'b0;
        push_vec(vecs[1]);
        wait_valid(20);
        chk("post_rst_beat0", {48'd0, data_l}, 64'h5555);
        chk("post_rst_msb0",  {48'd0, data_m}, 64'hFFFF);
        drain(1'b0, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
